// File: rtl/ps2_dir_decoder.sv
// PS/2 set-2 receiver driving held arrow-key flags, plus last byte and error strobes.
// Build option WASD_EN: letter keys W/S/A/D also drive the direction flags.
module ps2_dir_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_clk,
  input  logic       key_data,
  output logic       kup,
  output logic       kdown,
  output logic       kleft,
  output logic       kright,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          kclk_s1_q, kclk_s1_d, kclk_s2_q, kclk_s2_d;
  logic          kdat_s1_q, kdat_s1_d, kdat_s2_q, kdat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fe_q, fe_d;
  state_t        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [3:0]    flags_q, flags_d;   // {up, down, left, right}
  logic [7:0]    scan_q, scan_d;
  logic          cv_q, cv_d, err_q, err_d;
  logic          accept;

  always_comb begin
    kclk_s1_d = key_clk;
    kclk_s2_d = kclk_s1_q;
    kdat_s1_d = key_data;
    kdat_s2_d = kdat_s1_q;
    filt_d    = filt_q;
    fcnt_d    = fcnt_q;
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    flags_d   = flags_q;
    scan_d    = scan_q;
    cv_d      = 1'b0;
    err_d     = 1'b0;
    accept    = 1'b0;

    // Glitch filter: level follows the input only after FILTER_LEN differing samples.
    if (kclk_s2_q == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
      filt_d = kclk_s2_q;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + 1'b1;
    end
    fe_d = filt_q & ~filt_d;

    if (fe_q) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!kdat_s2_q) begin
            state_d = S_DATA;
            bcnt_d  = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d = {kdat_s2_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = kdat_s2_q;
          state_d = S_STOP;
        end
        default: begin
          if (kdat_s2_q && (^{shift_q, par_q})) accept = 1'b1;
          else                                  err_d  = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (accept) begin
      scan_d = shift_q;
      cv_d   = 1'b1;
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (ext_q) begin
          case (shift_q)
            8'h75:   flags_d[3] = ~brk_q;
            8'h72:   flags_d[2] = ~brk_q;
            8'h6B:   flags_d[1] = ~brk_q;
            8'h74:   flags_d[0] = ~brk_q;
            default: ;
          endcase
        end
`ifdef WASD_EN
        else begin
          case (shift_q)
            8'h1D:   flags_d[3] = ~brk_q;
            8'h1B:   flags_d[2] = ~brk_q;
            8'h1C:   flags_d[1] = ~brk_q;
            8'h23:   flags_d[0] = ~brk_q;
            default: ;
          endcase
        end
`endif
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end

    if (err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kclk_s1_q <= 1'b1;
      kclk_s2_q <= 1'b1;
      kdat_s1_q <= 1'b1;
      kdat_s2_q <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      fe_q      <= 1'b0;
      state_q   <= S_IDLE;
      bcnt_q    <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      flags_q   <= 4'h0;
      scan_q    <= 8'h00;
      cv_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      kclk_s1_q <= kclk_s1_d;
      kclk_s2_q <= kclk_s2_d;
      kdat_s1_q <= kdat_s1_d;
      kdat_s2_q <= kdat_s2_d;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      fe_q      <= fe_d;
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      flags_q   <= flags_d;
      scan_q    <= scan_d;
      cv_q      <= cv_d;
      err_q     <= err_d;
    end
  end

  assign kup        = flags_q[3];
  assign kdown      = flags_q[2];
  assign kleft      = flags_q[1];
  assign kright     = flags_q[0];
  assign scan_code  = scan_q;
  assign code_valid = cv_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Bench for ps2_dir_decoder: directed vector table, timeout/reset sequences, random frames vs a byte-level model.
module tb_ps2_dir_decoder;
  localparam int HALF = 40;
  localparam int TMO  = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_clk, key_data;
  logic       kup, kdown, kleft, kright;
  logic [7:0] scan_code;
  logic       code_valid, frame_err;

  ps2_dir_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .key_clk(key_clk), .key_data(key_data),
    .kup(kup), .kdown(kdown), .kleft(kleft), .kright(kright),
    .scan_code(scan_code), .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0, failed = 0;
  int cv_cnt = 0, err_cnt = 0, overlap = 0;

  always @(negedge clk) begin
    if (code_valid) cv_cnt++;
    if (frame_err) err_cnt++;
    if (code_valid && frame_err) overlap++;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {kup, kdown, kleft, kright};
  endfunction

  // Device-side framing: data changes while clock is high, host samples on the falling edge.
  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      key_data = f[i];
      repeat (HALF) @(posedge clk);
      key_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      key_clk = 1'b1;
    end
    key_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad;
    logic [3:0] fl;
    int         cv;
    int         er;
    logic [7:0] sc;
  } vec_t;

`ifdef WASD_EN
  localparam logic [3:0] WF = 4'h7;
`else
  localparam logic [3:0] WF = 4'h3;
`endif

  // Byte-level reference model
  bit         m_ext, m_brk;
  bit         m_fl [4];
  logic [7:0] m_scan;

  function automatic int key_index(input logic [7:0] b, input bit ext);
    logic [7:0] arrows [4];
    logic [7:0] wasd [4];
    arrows = '{8'h75, 8'h72, 8'h6B, 8'h74};
    wasd   = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    for (int k = 0; k < 4; k++) begin
      if (ext && b == arrows[k]) return k;
`ifdef WASD_EN
      if (!ext && b == wasd[k]) return k;
`endif
    end
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit bad);
    int k;
    if (bad) begin
      m_ext = 0;
      m_brk = 0;
    end else begin
      m_scan = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        k = key_index(b, m_ext);
        if (k >= 0) m_fl[k] = !m_brk;
        m_ext = 0;
        m_brk = 0;
      end
    end
  endtask

  initial begin
    vec_t       tbl [21];
    int         cv0, er0;
    logic [7:0] pool [10];
    logic [7:0] b;
    bit         bad;

    tbl[0]  = '{8'hE0, 0, 4'h0, 1, 0, 8'hE0};
    tbl[1]  = '{8'h75, 0, 4'h8, 1, 0, 8'h75};
    tbl[2]  = '{8'hE0, 0, 4'h8, 1, 0, 8'hE0};
    tbl[3]  = '{8'hF0, 0, 4'h8, 1, 0, 8'hF0};
    tbl[4]  = '{8'h75, 0, 4'h0, 1, 0, 8'h75};
    tbl[5]  = '{8'h74, 1, 4'h0, 0, 1, 8'h75};
    tbl[6]  = '{8'hE0, 0, 4'h0, 1, 0, 8'hE0};
    tbl[7]  = '{8'h74, 0, 4'h1, 1, 0, 8'h74};
    tbl[8]  = '{8'hE0, 0, 4'h1, 1, 0, 8'hE0};
    tbl[9]  = '{8'h75, 0, 4'h9, 1, 0, 8'h75};
    tbl[10] = '{8'hE0, 0, 4'h9, 1, 0, 8'hE0};
    tbl[11] = '{8'h6B, 0, 4'hB, 1, 0, 8'h6B};
    tbl[12] = '{8'hE0, 0, 4'hB, 1, 0, 8'hE0};
    tbl[13] = '{8'hF0, 0, 4'hB, 1, 0, 8'hF0};
    tbl[14] = '{8'h75, 0, 4'h3, 1, 0, 8'h75};
    tbl[15] = '{8'hE0, 0, 4'h3, 1, 0, 8'hE0};
    tbl[16] = '{8'h72, 1, 4'h3, 0, 1, 8'hE0};
    tbl[17] = '{8'h75, 0, 4'h3, 1, 0, 8'h75};
    tbl[18] = '{8'h1B, 0, WF,   1, 0, 8'h1B};
    tbl[19] = '{8'hF0, 0, WF,   1, 0, 8'hF0};
    tbl[20] = '{8'h1B, 0, 4'h3, 1, 0, 8'h1B};
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23};

    key_clk = 1'b1;
    key_data = 1'b1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_flags", int'(flags()), 0);
    check("rst_scan", int'(scan_code), 0);
    check("rst_cv", int'(code_valid), 0);
    check("rst_err", int'(frame_err), 0);
    rst = 1'b1;
    repeat (10000) @(posedge clk);
    @(negedge clk);
    check("idle_cv", cv_cnt, 0);
    check("idle_err", err_cnt, 0);

    // Timeout mid-frame must clear the pending E0
    send_frame(8'hE0, 0, 11);
    cv0 = cv_cnt; er0 = err_cnt;
    send_frame(8'h00, 0, 5);
    repeat (TMO + 300) @(posedge clk);
    @(negedge clk);
    check("tmo_err", err_cnt - er0, 1);
    check("tmo_cv", cv_cnt - cv0, 0);
    send_frame(8'h6B, 0, 11);
    check("tmo_ext_clr", int'(flags()), 0);
    check("tmo_scan", int'(scan_code), 8'h6B);
    send_frame(8'hE0, 0, 11);
    send_frame(8'h6B, 0, 11);
    check("tmo_kleft", int'(flags()), 4'h2);
    send_frame(8'hE0, 0, 11);
    send_frame(8'hF0, 0, 11);
    send_frame(8'h6B, 0, 11);
    check("tmo_release", int'(flags()), 0);

    for (int i = 0; i < 21; i++) begin
      cv0 = cv_cnt; er0 = err_cnt;
      send_frame(tbl[i].code, tbl[i].bad, 11);
      check($sformatf("tbl%0d_flags", i), int'(flags()), int'(tbl[i].fl));
      check($sformatf("tbl%0d_scan", i), int'(scan_code), int'(tbl[i].sc));
      check($sformatf("tbl%0d_cv", i), cv_cnt - cv0, tbl[i].cv);
      check($sformatf("tbl%0d_err", i), err_cnt - er0, tbl[i].er);
    end

    m_ext = 0; m_brk = 0; m_scan = 8'h1B;
    m_fl = '{0, 0, 1, 1};
    for (int i = 0; i < 30; i++) begin
      b = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 9)];
      bad = ($urandom_range(0, 7) == 0);
      cv0 = cv_cnt; er0 = err_cnt;
      send_frame(b, bad, 11);
      model_byte(b, bad);
      check($sformatf("rnd%0d_flags", i), int'(flags()), int'({m_fl[0], m_fl[1], m_fl[2], m_fl[3]}));
      check($sformatf("rnd%0d_scan", i), int'(scan_code), int'(m_scan));
      check($sformatf("rnd%0d_cv", i), cv_cnt - cv0, bad ? 0 : 1);
      check($sformatf("rnd%0d_err", i), err_cnt - er0, bad ? 1 : 0);
    end

    // Reset with a partial byte in the shifter
    cv0 = cv_cnt; er0 = err_cnt;
    send_frame(8'hA5, 0, 6);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (TMO + 300) @(posedge clk);
    @(negedge clk);
    check("mrst_cv", cv_cnt - cv0, 0);
    check("mrst_err", err_cnt - er0, 0);
    check("mrst_flags", int'(flags()), 0);
    check("mrst_scan", int'(scan_code), 0);
    send_frame(8'hE0, 0, 11);
    send_frame(8'h75, 0, 11);
    check("mrst_kup", int'(flags()), 4'h8);
    check("no_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
